// File: rtl/divider_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The master issues divide requests; the slave (the divider) answers with ready/done/result.
interface divider_unit_if;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        is_signed;
  logic        is_rem;
  logic        is_word;
  logic        done;
  logic [63:0] result;

  modport master (
    output flush, valid, a, b, is_signed, is_rem, is_word,
    input  ready, done, result
  );

  modport slave (
    input  flush, valid, a, b, is_signed, is_rem, is_word,
    output ready, done, result
  );
endinterface

// File: rtl/divider_unit.sv
// Iterative restoring radix-2 divider for the RV64 M-extension DIV/REM family.
// Divide-by-zero and signed overflow bypass the 64-cycle loop and complete on the accept edge.
module divider_unit (
  input  logic          clk,
  input  logic          reset,
  divider_unit_if.slave dif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [6:0]  cnt_r;
  logic [63:0] quo_r;
  logic [63:0] rem_r;
  logic [63:0] dvs_r;
  logic [63:0] result_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        is_rem_r;
  logic        is_word_r;
  logic        done_r;
  logic        ready_r;

  logic        accept_s;
  logic        div_zero_s;
  logic        ovf_s;
  logic        special_s;
  logic        last_iter_s;
  logic [63:0] abs_a_s;
  logic [63:0] abs_b_s;
  logic [63:0] spec_sel_s;
  logic [63:0] spec_res_s;
  logic [64:0] shift_s;
  logic [63:0] quo_nxt_s;
  logic [63:0] rem_nxt_s;
  logic [63:0] final_sel_s;
  logic [63:0] final_res_s;

  function automatic logic [63:0] neg_if(input logic [63:0] v, input logic n);
    if (n) begin
      neg_if = 64'd0 - v;
    end else begin
      neg_if = v;
    end
  endfunction

  // W results are always the low word sign-extended, even for the unsigned variants.
  function automatic logic [63:0] fmt_res(input logic [63:0] v, input logic w);
    if (w) begin
      fmt_res = {{32{v[31]}}, v[31:0]};
    end else begin
      fmt_res = v;
    end
  endfunction

  assign dif.ready  = ready_r;
  assign dif.done   = done_r;
  assign dif.result = result_r;

  // Request decode: acceptance, special-case detection and operand magnitudes.
  always_comb begin
    accept_s = (state_r == IDLE) && dif.valid && !dif.flush;
    if (dif.is_word) begin
      div_zero_s = (dif.b[31:0] == 32'd0);
      ovf_s      = dif.is_signed && (dif.a[31:0] == 32'h8000_0000) &&
                   (dif.b[31:0] == 32'hFFFF_FFFF);
    end else begin
      div_zero_s = (dif.b == 64'd0);
      ovf_s      = dif.is_signed && (dif.a == 64'h8000_0000_0000_0000) &&
                   (dif.b == 64'hFFFF_FFFF_FFFF_FFFF);
    end
    special_s = div_zero_s || ovf_s;
    abs_a_s   = neg_if(dif.a, dif.is_signed & dif.a[63]);
    abs_b_s   = neg_if(dif.b, dif.is_signed & dif.b[63]);
    if (dif.is_rem) begin
      spec_sel_s = div_zero_s ? dif.a : 64'd0;
    end else begin
      spec_sel_s = div_zero_s ? 64'hFFFF_FFFF_FFFF_FFFF : dif.a;
    end
    spec_res_s = fmt_res(spec_sel_s, dif.is_word);
  end

  // One restoring step plus sign/word fix-up of the value it would produce.
  always_comb begin
    shift_s = {rem_r, quo_r[63]};
    if (shift_s >= {1'b0, dvs_r}) begin
      rem_nxt_s = shift_s[63:0] - dvs_r;
      quo_nxt_s = {quo_r[62:0], 1'b1};
    end else begin
      rem_nxt_s = shift_s[63:0];
      quo_nxt_s = {quo_r[62:0], 1'b0};
    end
    if (is_rem_r) begin
      final_sel_s = neg_if(rem_nxt_s, neg_r_r);
    end else begin
      final_sel_s = neg_if(quo_nxt_s, neg_q_r);
    end
    final_res_s = fmt_res(final_sel_s, is_word_r);
    last_iter_s = (cnt_r == 7'd63);
  end

  // Next-state logic; flush wins over both acceptance and completion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = special_s ? DONE : BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (dif.flush) begin
          state_nxt_s = IDLE;
        end else if (last_iter_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == DONE);
      ready_r <= (state_nxt_s == IDLE);
    end
  end

  // Datapath: operand capture, iteration, and result update on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= 7'd0;
      quo_r     <= 64'd0;
      rem_r     <= 64'd0;
      dvs_r     <= 64'd0;
      result_r  <= 64'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      is_rem_r  <= 1'b0;
      is_word_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r     <= 7'd0;
            quo_r     <= abs_a_s;
            rem_r     <= 64'd0;
            dvs_r     <= abs_b_s;
            neg_q_r   <= dif.is_signed & (dif.a[63] ^ dif.b[63]);
            neg_r_r   <= dif.is_signed & dif.a[63];
            is_rem_r  <= dif.is_rem;
            is_word_r <= dif.is_word;
            if (special_s) begin
              result_r <= spec_res_s;
            end
          end
        end
        BUSY: begin
          if (!dif.flush) begin
            cnt_r <= cnt_r + 7'd1;
            quo_r <= quo_nxt_s;
            rem_r <= rem_nxt_s;
            if (last_iter_s) begin
              result_r <= final_res_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port flush, input, 1, synchronous abort of any operation in progress.
REQ-004 SHALL have port valid, input, 1, request to start a divide.
REQ-005 SHALL have port ready, output, 1, high only when a request can be accepted.
REQ-006 SHALL have port a, input, 64, dividend: the execute-stage rd1 operand.
REQ-007 SHALL have port b, input, 64, divisor: the execute-stage rd2 operand.
REQ-008 SHALL have port is_signed, input, 1, high for DIV/REM/DIVW/REMW.
REQ-009 SHALL have port is_rem, input, 1, high to return the remainder, low to return the quotient.
REQ-010 SHALL have port is_word, input, 1, high for the W variants.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port result, output, 64, final quotient or remainder.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE; ready=1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge where valid=1, ready=1 and flush=0, capturing a, b, is_signed, is_rem and is_word; inputs are ignored at all other times.
REQ-015 SHALL treat a and b as already sign- or zero-extended from bit 31 by decode for W ops, and perform the full 64-bit divide on them.
REQ-016 SHALL, on a signed op, divide absolute values; the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-017 SHALL perform one restoring radix-2 iteration per cycle in BUSY, using a 7-bit counter for 64 iterations; after the 64th iteration edge the state becomes DONE.
REQ-018 SHALL, when b==0, go from accept directly to DONE: quotient = all ones; remainder = a.
REQ-019 SHALL, when is_signed=1 and a=0x8000_0000_0000_0000 and b=all ones, go directly to DONE: quotient = a; remainder = 0.
REQ-020 SHALL, on the W variants, take divide-by-zero and overflow from the 32-bit view: a[31:0]=0x8000_0000 and b[31:0]=0xFFFF_FFFF.
REQ-021 SHALL, for is_word=1, drive result as the selected value's bits [31:0] sign-extended to 64 bits, for both signed and unsigned ops.
REQ-022 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-023 SHALL set result when entering DONE and hold it stable until the next entry to DONE.
REQ-024 SHALL have the following latency, where T0 is the accept edge:
  - normal: done is high between edges T64 and T65.
  - special-case: done is high between edges T0 and T1.
REQ-025 SHALL, when flush=1 on any edge, go to IDLE with no done pulse; flush takes priority over valid and over completion.
REQ-026 SHALL leave result unchanged on flush.

Reset
REQ-027 SHALL, when reset=1 on an edge, set the state to IDLE, the counter to 0 and result to 0; done is then 0 and ready is 1 from the next cycle.
REQ-028 SHALL give reset priority over flush and valid, and SHALL abort an operation in progress with no done pulse.

Verification
REQ-029 SHALL cover unsigned 64-bit: a=100, b=7, is_rem=0 -> result=14 exactly 65 edges after accept; with is_rem=1 -> result=2.
REQ-030 SHALL cover signed: a=-7, b=2 -> DIV result=-3, REM result=-1; a=7, b=-2 -> DIV result=-3, REM result=1.
REQ-031 SHALL cover divide-by-zero: b=0, a=0x1234 -> DIV result=0xFFFF_FFFF_FFFF_FFFF; REM result=0x1234; done one cycle after accept.
REQ-032 SHALL cover the overflow cases:
  - DIV a=0x8000_0000_0000_0000, b=-1 -> result=a.
  - DIVW a=sext(0x8000_0000), b=-1 -> result=0xFFFF_FFFF_8000_0000.
  - REMW of the same operands -> result=0.
REQ-033 SHALL cover unsigned W sign-extension: DIVUW a=0xFFFF_FFFE, b=1 -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-034 SHALL cover abort:
  - flush at iteration 30 -> no done and ready=1 next cycle; a new request then completes correctly.
  - reset at iteration 10 -> same recovery; result=0.
  - valid and flush asserted together -> request not accepted.
